// File: rtl/serial_addsub.sv
// Bit-serial WIDTH-bit adder/subtractor: one full-adder cell, registered carry, LSB first.
// Optional zero flag output enabled by defining SERIAL_ADDSUB_ZERO_FLAG_EN.
module serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
    output logic             zero,
`endif
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sh;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic             w_accept;
    logic             w_last;
    logic             w_s;
    logic             w_co;
    logic [WIDTH-1:0] w_sh_next;
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
    logic             r_zacc;
`endif

    function automatic logic maj3(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    assign w_accept  = (r_state == S_IDLE) && start;
    assign w_last    = (r_state == S_RUN) && (r_cnt == LAST);
    assign w_s       = r_a[0] ^ r_b[0] ^ r_carry;
    assign w_co      = maj3(r_a[0], r_b[0], r_carry);
    assign w_sh_next = {w_s, r_sh[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            S_IDLE: if (start) w_next = S_RUN;
            S_RUN: begin
                busy = 1'b1;
                if (r_cnt == LAST) w_next = S_DONE;
            end
            S_DONE: begin
                busy   = 1'b1;
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Serial datapath: subtraction is a + ~b + 1, the +1 entering as the initial carry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_sh     <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            result   <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
            r_zacc   <= 1'b0;
            zero     <= 1'b0;
`endif
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= sub;
            r_cnt   <= '0;
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
            r_zacc  <= 1'b1;
`endif
        end else if (r_state == S_RUN) begin
            r_a     <= {1'b0, r_a[WIDTH-1:1]};
            r_b     <= {1'b0, r_b[WIDTH-1:1]};
            r_sh    <= w_sh_next;
            r_carry <= w_co;
            r_cnt   <= r_cnt + 1'b1;
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
            r_zacc  <= r_zacc & ~w_s;
`endif
            if (w_last) begin
                // On the MSB cycle r_carry is the carry into the sign bit.
                result   <= w_sh_next;
                cout     <= w_co;
                overflow <= r_carry ^ w_co;
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
                zero     <= r_zacc & ~w_s;
`endif
            end
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub (WIDTH=8): latency, arithmetic, flags, ignored starts, reset abort.
module tb_serial_addsub;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         overflow;
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
    logic         zero;
`endif

    int checks = 0;
    int errors = 0;

    serial_addsub #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .sub      (sub),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout     (cout),
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
        .zero     (zero),
`endif
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                          input logic isub, input logic [7:0] er, input logic ec,
                          input logic eo, input bit noise);
        logic [7:0] prev;
        int n;
        int busyn;
        int donen;
        prev  = result;
        a     = ia;
        b     = ib;
        sub   = isub;
        start = 1'b1;
        tick();
        if (noise) begin
            a   = 8'hFF;
            b   = 8'hFF;
            sub = 1'b1;
        end else begin
            start = 1'b0;
        end
        n     = 0;
        busyn = 0;
        while (!done && n < 20) begin
            if (busy) busyn++;
            if (n == 4) chk({tag, ":mid_result_hold"}, 32'(result), 32'(prev));
            tick();
            n++;
        end
        if (busy) busyn++;
        donen = int'(done);
        chk({tag, ":latency"}, n, W);
        chk({tag, ":result"}, 32'(result), 32'(er));
        chk({tag, ":cout"}, 32'(cout), 32'(ec));
        chk({tag, ":overflow"}, 32'(overflow), 32'(eo));
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
        chk({tag, ":zero"}, 32'(zero), 32'(er == 8'h00));
`endif
        tick();
        start = 1'b0;
        chk({tag, ":busy_after"}, 32'(busy), 32'd0);
        chk({tag, ":result_held"}, 32'(result), 32'(er));
        for (int k = 0; k < 2; k++) begin
            donen += int'(done);
            tick();
        end
        chk({tag, ":done_pulses"}, donen, 1);
        chk({tag, ":busy_cycles"}, busyn, W + 1);
        chk({tag, ":result_idle"}, 32'(result), 32'(er));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach summary");
        $fatal(1, "timeout");
    end

    initial begin
        int dn;
        int bn;
        rst   = 1'b1;
        start = 1'b0;
        sub   = 1'b0;
        a     = '0;
        b     = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
        tick();
        chk("reset:busy", 32'(busy), 32'd0);
        chk("reset:done", 32'(done), 32'd0);
        chk("reset:result", 32'(result), 32'h00);
        chk("reset:cout", 32'(cout), 32'd0);
        chk("reset:overflow", 32'(overflow), 32'd0);
`ifdef SERIAL_ADDSUB_ZERO_FLAG_EN
        chk("reset:zero", 32'(zero), 32'd0);
`endif

        run_op("add_3C_05", 8'h3C, 8'h05, 1'b0, 8'h41, 1'b0, 1'b0, 1'b0);
        run_op("sub_05_3C", 8'h05, 8'h3C, 1'b1, 8'hC9, 1'b0, 1'b0, 1'b0);
        run_op("add_7F_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
        run_op("add_FF_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        run_op("ignore_start", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 1'b1);
        run_op("sub_80_01", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0);

        // Abort mid-operation with reset on the fourth RUN edge.
        a     = 8'h55;
        b     = 8'h22;
        sub   = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort:busy", 32'(busy), 32'd0);
        chk("abort:done", 32'(done), 32'd0);
        chk("abort:result", 32'(result), 32'h00);
        chk("abort:cout", 32'(cout), 32'd0);
        chk("abort:overflow", 32'(overflow), 32'd0);
        dn = 0;
        bn = 0;
        for (int k = 0; k < 12; k++) begin
            dn += int'(done);
            bn += int'(busy);
            tick();
        end
        chk("abort:no_done", dn, 0);
        chk("abort:stays_idle", bn, 0);

        run_op("after_abort", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
